// File: rtl/tolower_stream_if.sv
// Byte stream bundle for tolower_stream: input side (valid/ready/data) and
// output side (valid/ready/data plus a per-byte "changed" flag).
interface tolower_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_changed;

    // Converter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_changed
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_changed
    );
endinterface

// File: rtl/tolower_stream.sv
// Byte-serial ASCII lowercase converter with a 2-entry output buffer and
// saturating byte/converted statistics counters.
module tolower_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    tolower_stream_if.slave  strm,
    input  logic             count_clr,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] conv_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t       state;
    logic [7:0] head_data;
    logic       head_changed;
    logic [7:0] skid_data;
    logic       skid_changed;
    logic       out_valid_q;
    logic       in_ready_q;

    logic       hit;
    logic [7:0] conv_data;
    logic       push;
    logic       pop;

    // The decision is taken once, at acceptance, and stored with the byte.
    assign hit       = enable && (strm.in_data >= 8'h41) && (strm.in_data <= 8'h5A);
    assign conv_data = hit ? (strm.in_data | 8'h20) : strm.in_data;
    assign push      = strm.in_valid && in_ready_q;
    assign pop       = out_valid_q && strm.out_ready;

    assign strm.in_ready    = in_ready_q;
    assign strm.out_valid   = out_valid_q;
    assign strm.out_data    = head_data;
    assign strm.out_changed = head_changed;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            head_data    <= 8'h00;
            head_changed <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (push) begin
                        head_data    <= conv_data;
                        head_changed <= hit;
                        out_valid_q  <= 1'b1;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (push) begin
                        head_data    <= conv_data;
                        head_changed <= hit;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so a pop only promotes the skid byte.
                    if (pop) begin
                        head_data    <= skid_data;
                        head_changed <= skid_changed;
                        in_ready_q   <= 1'b1;
                        state        <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // NOTE: the skid entry is storage, not control; it is only read after being
    // written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ONE && push && !pop) begin
            skid_data    <= conv_data;
            skid_changed <= hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= '0;
            conv_count <= '0;
        end else if (count_clr) begin
            byte_count <= '0;
            conv_count <= '0;
        end else if (push) begin
            if (byte_count != '1) byte_count <= byte_count + CNT_W'(1);
            if (hit && conv_count != '1) conv_count <= conv_count + CNT_W'(1);
        end
    end

endmodule
